// File: rtl/calc_req_driver.sv
// Request engine for one calc1_top port: queues operations, serialises op1/op2, returns the response.
// Optional WAIT-state watchdog enabled by defining CALC_REQ_TIMEOUT_EN.
module calc_req_driver #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_cmd,
  input  logic [31:0]                   in_op1,
  input  logic [31:0]                   in_op2,
  output logic [3:0]                    req_cmd_out,
  output logic [31:0]                   req_data_out,
  input  logic [1:0]                    out_resp,
  input  logic [31:0]                   out_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [3:0]                    rsp_cmd,
  output logic [1:0]                    rsp_resp,
  output logic [31:0]                   rsp_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } op_t;

  typedef enum logic [2:0] {S_IDLE, S_OP1, S_OP2, S_WAIT, S_HOLD} state_t;

  op_t           mem [FIFO_DEPTH];
  op_t           head;
  op_t           cur;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;
  logic          timeout;
  state_t        state;
  state_t        state_d;

  logic [3:0]    req_cmd_d;
  logic [31:0]   req_data_d;
  logic          rsp_valid_d;
  logic [3:0]    rsp_cmd_d;
  logic [1:0]    rsp_resp_d;
  logic [31:0]   rsp_data_d;

  assign push = in_valid && in_ready;
  assign pop  = (state == S_IDLE) && (fifo_count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_d = fifo_count;
    unique case ({push, pop})
      2'b10:   count_d = fifo_count + CW'(1);
      2'b01:   count_d = fifo_count - CW'(1);
      default: count_d = fifo_count;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr] <= '{cmd: in_cmd, op1: in_op1, op2: in_op2};
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cur    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        cur    <= head;
      end
    end
  end

`ifdef CALC_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts WAIT cycles; held at zero everywhere else so each WAIT entry starts fresh.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset)               tmo_cnt <= '0;
    else if (state != S_WAIT) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (pop) state_d = (head.cmd != 4'd0) ? S_OP1 : S_HOLD;
      S_OP1:   state_d = S_OP2;
      S_OP2:   state_d = S_WAIT;
      S_WAIT:  if ((out_resp != 2'd0) || timeout) state_d = S_HOLD;
      S_HOLD:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; a real response beats a same-cycle timeout.
  always_comb begin
    req_cmd_d   = 4'd0;
    req_data_d  = 32'd0;
    rsp_valid_d = rsp_valid;
    rsp_cmd_d   = rsp_cmd;
    rsp_resp_d  = rsp_resp;
    rsp_data_d  = rsp_data;
    unique case (state)
      S_IDLE: begin
        if (pop && (head.cmd == 4'd0)) begin
          rsp_valid_d = 1'b1;
          rsp_cmd_d   = 4'd0;
          rsp_resp_d  = 2'd0;
          rsp_data_d  = 32'd0;
        end
      end
      S_OP1: begin
        req_cmd_d  = cur.cmd;
        req_data_d = cur.op1;
      end
      S_OP2: req_data_d = cur.op2;
      S_WAIT: begin
        if (out_resp != 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_cmd_d   = cur.cmd;
          rsp_resp_d  = out_resp;
          rsp_data_d  = out_data;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_cmd_d   = cur.cmd;
          rsp_resp_d  = 2'b11;
          rsp_data_d  = 32'hDEAD_BEEF;
        end
      end
      S_HOLD:  if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      req_cmd_out  <= '0;
      req_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_cmd      <= '0;
      rsp_resp     <= '0;
      rsp_data     <= '0;
      busy         <= 1'b0;
      fifo_count   <= '0;
      in_ready     <= 1'b1;
    end else begin
      req_cmd_out  <= req_cmd_d;
      req_data_out <= req_data_d;
      rsp_valid    <= rsp_valid_d;
      rsp_cmd      <= rsp_cmd_d;
      rsp_resp     <= rsp_resp_d;
      rsp_data     <= rsp_data_d;
      busy         <= (state_d != S_IDLE);
      fifo_count   <= count_d;
      in_ready     <= (count_d != CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_calc_req_driver.sv
// Scoreboard bench for calc_req_driver; inputs change on falling edges, outputs sampled there too.
`timescale 1ns/1ps
module tb_calc_req_driver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          c_clk    = 1'b0;
  logic          reset    = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_cmd   = '0;
  logic [31:0]   in_op1   = '0;
  logic [31:0]   in_op2   = '0;
  logic [3:0]    req_cmd_out;
  logic [31:0]   req_data_out;
  logic [1:0]    out_resp = '0;
  logic [31:0]   out_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [3:0]    rsp_cmd;
  logic [1:0]    rsp_resp;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [CW-1:0] fifo_count;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 c_clk = ~c_clk;

  calc_req_driver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cmd(rsp_cmd), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Enters and leaves on a falling edge; returns on the edge after acceptance.
  task automatic push_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
    rsp_t t;
    int   n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge c_clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL push_ready: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
    t.cmd = c; t.resp = er; t.data = ed;
    exp_q.push_back(t);
    @(negedge c_clk);
    in_valid = 1'b0;
  endtask

  task automatic reply(input logic [1:0] r, input logic [31:0] d);
    out_resp = r; out_data = d;
    @(negedge c_clk);
    out_resp = '0; out_data = '0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge c_clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if ({req_cmd_out, req_data_out, rsp_valid, rsp_cmd, rsp_resp, rsp_data, busy, fifo_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%h/%h rsp=%b/%h/%h/%h busy=%b cnt=%0d want all 0",
               req_cmd_out, req_data_out, rsp_valid, rsp_cmd, rsp_resp, rsp_data, busy, fifo_count);
    end
    reset = 1'b1;
    @(negedge c_clk);
  endtask

  task automatic test_single_op();
    rsp_t e;
    push_op(4'd1, 32'd5, 32'd7, 2'd1, 32'd12);
    @(negedge c_clk);
    vectors++;
    if (req_cmd_out !== 4'd0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL single_early: req_cmd=%h busy=%b want 0/1", req_cmd_out, busy);
    end
    @(negedge c_clk);
    vectors++;
    if (req_cmd_out !== 4'd1 || req_data_out !== 32'd5) begin
      miscompares++; $display("FAIL single_op1: got %h/%h want 1/5", req_cmd_out, req_data_out);
    end
    @(negedge c_clk);
    vectors++;
    if (req_cmd_out !== 4'd0 || req_data_out !== 32'd7) begin
      miscompares++; $display("FAIL single_op2: got %h/%h want 0/7", req_cmd_out, req_data_out);
    end
    @(negedge c_clk);
    @(negedge c_clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 || req_data_out !== 32'd0) begin
      miscompares++;
      $display("FAIL single_wait: rsp_valid=%b req=%h/%h want 0/0/0", rsp_valid, req_cmd_out, req_data_out);
    end
    reply(2'd1, 32'd12);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vectors++;
    if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e) begin
      miscompares++;
      $display("FAIL single_rsp: got v=%b %h/%h/%h want 1 %h/%h/%h",
               rsp_valid, rsp_cmd, rsp_resp, rsp_data, e.cmd, e.resp, e.data);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_release: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds [5];
    logic [31:0] a [5];
    logic [31:0] b [5];
    rsp_t t;
    rsp_t e;
    int   acc = 0;
    int   n   = 0;
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1};
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'h100 + 32'(i);
      b[i] = 32'(i + 1);
    end
    while (acc < 5 && n < 40) begin
      if (in_ready === 1'b1) begin
        in_valid = 1'b1; in_cmd = cmds[acc]; in_op1 = a[acc]; in_op2 = b[acc];
        t.cmd = cmds[acc]; t.resp = 2'd1; t.data = a[acc] ^ b[acc];
        exp_q.push_back(t);
        acc++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge c_clk);
      n++;
    end
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'hBAD; in_op2 = 32'hBAD;
    vectors++;
    if (acc != 5 || in_ready !== 1'b0 || fifo_count !== CW'(4)) begin
      miscompares++;
      $display("FAIL b2b_full: accepted=%0d in_ready=%b cnt=%0d want 5/0/4", acc, in_ready, fifo_count);
    end
    repeat (3) @(negedge c_clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || fifo_count !== CW'(4)) begin
      miscompares++; $display("FAIL b2b_hold: in_ready=%b cnt=%0d want 0/4", in_ready, fifo_count);
    end
    reply(2'd1, a[0] ^ b[0]);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        vectors++;
        if (req_cmd_out !== cmds[i] || req_data_out !== a[i]) begin
          miscompares++;
          $display("FAIL b2b_op1[%0d]: got %h/%h want %h/%h", i, req_cmd_out, req_data_out, cmds[i], a[i]);
        end
        @(negedge c_clk);
        vectors++;
        if (req_cmd_out !== 4'd0 || req_data_out !== b[i]) begin
          miscompares++;
          $display("FAIL b2b_op2[%0d]: got %h/%h want 0/%h", i, req_cmd_out, req_data_out, b[i]);
        end
        @(negedge c_clk);
        @(negedge c_clk);
        reply(2'd1, a[i] ^ b[i]);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      vectors++;
      if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: got v=%b %h/%h/%h want 1 %h/%h/%h",
                 i, rsp_valid, rsp_cmd, rsp_resp, rsp_data, e.cmd, e.resp, e.data);
      end
      rsp_ready = 1'b1;
      @(negedge c_clk);
      rsp_ready = 1'b0;
      @(negedge c_clk);
      vectors++;
      if (rsp_valid !== 1'b0 || req_cmd_out !== 4'd0) begin
        miscompares++;
        $display("FAIL b2b_gap[%0d]: rsp_valid=%b req_cmd=%h want 0/0", i, rsp_valid, req_cmd_out);
      end
      @(negedge c_clk);
    end
    vectors++;
    if (fifo_count !== '0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain: cnt=%0d busy=%b want 0/0", fifo_count, busy);
    end
  endtask

  task automatic test_backpressure();
    rsp_t e;
    int   n = 0;
    push_op(4'd2, 32'd3, 32'd10, 2'd1, 32'd7);
    push_op(4'd1, 32'h11, 32'h22, 2'd2, 32'hCAFE);
    while (req_cmd_out === 4'd0 && n < 20) begin @(negedge c_clk); n++; end
    vectors++;
    if (req_cmd_out !== 4'd2 || req_data_out !== 32'd3) begin
      miscompares++; $display("FAIL bp_op1: got %h/%h want 2/3", req_cmd_out, req_data_out);
    end
    @(negedge c_clk);
    @(negedge c_clk);
    reply(2'd1, 32'd7);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    for (int k = 0; k < 10; k++) begin
      out_resp = 2'd3; out_data = 32'h5A5A_0000 + 32'(k);
      vectors++;
      if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e || req_cmd_out !== 4'd0 ||
          fifo_count !== CW'(1)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: v=%b %h/%h/%h req=%h cnt=%0d want 1 %h/%h/%h req=0 cnt=1",
                 k, rsp_valid, rsp_cmd, rsp_resp, rsp_data, req_cmd_out, fifo_count, e.cmd, e.resp, e.data);
      end
      @(negedge c_clk);
    end
    out_resp = '0; out_data = '0;
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    n = 0;
    while (req_cmd_out === 4'd0 && n < 20) begin @(negedge c_clk); n++; end
    vectors++;
    if (req_cmd_out !== 4'd1 || req_data_out !== 32'h11) begin
      miscompares++; $display("FAIL bp_next_op1: got %h/%h want 1/11", req_cmd_out, req_data_out);
    end
    @(negedge c_clk);
    @(negedge c_clk);
    reply(2'd2, 32'hCAFE);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vectors++;
    if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e) begin
      miscompares++;
      $display("FAIL bp_next_rsp: got v=%b %h/%h/%h want 1 %h/%h/%h",
               rsp_valid, rsp_cmd, rsp_resp, rsp_data, e.cmd, e.resp, e.data);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_noop();
    rsp_t e;
    logic seen_req = 1'b0;
    push_op(4'd0, 32'd9, 32'd9, 2'd0, 32'd0);
    seen_req = seen_req | (req_cmd_out !== 4'd0);
    @(negedge c_clk);
    seen_req = seen_req | (req_cmd_out !== 4'd0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vectors++;
    if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e) begin
      miscompares++;
      $display("FAIL noop_rsp: got v=%b %h/%h/%h want 1 %h/%h/%h",
               rsp_valid, rsp_cmd, rsp_resp, rsp_data, e.cmd, e.resp, e.data);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen_req = seen_req | (req_cmd_out !== 4'd0);
      @(negedge c_clk);
    end
    vectors++;
    if (seen_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL noop_quiet: req_seen=%b busy=%b rsp_valid=%b want 0/0/0", seen_req, busy, rsp_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    logic bad = 1'b0;
    int   n   = 0;
    push_op(4'd6, 32'd8, 32'd1, 2'd1, 32'd0);
    push_op(4'd1, 32'd2, 32'd3, 2'd1, 32'd0);
    while (req_cmd_out === 4'd0 && n < 20) begin @(negedge c_clk); n++; end
    repeat (3) @(negedge c_clk);
    vectors++;
    if (busy !== 1'b1 || fifo_count !== CW'(1)) begin
      miscompares++; $display("FAIL rstw_pre: busy=%b cnt=%0d want 1/1", busy, fifo_count);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({req_cmd_out, req_data_out, rsp_valid, rsp_cmd, rsp_resp, rsp_data, busy, fifo_count} !== '0 ||
        in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstw_async: busy=%b cnt=%0d rsp_valid=%b in_ready=%b want 0/0/0/1",
               busy, fifo_count, rsp_valid, in_ready);
    end
    exp_q.delete();
    @(negedge c_clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      out_resp = 2'd1; out_data = 32'h1234_0000 + 32'(k);
      @(negedge c_clk);
      bad = bad | (rsp_valid !== 1'b0) | (busy !== 1'b0) | (req_cmd_out !== 4'd0);
    end
    out_resp = '0; out_data = '0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("FAIL rstw_after: spurious activity=%b want 0", bad);
    end
  endtask

  task automatic test_timeout();
    rsp_t e;
    int   n = 0;
    push_op(4'd5, 32'd1, 32'd2, 2'b11, 32'hDEAD_BEEF);
    while (req_cmd_out === 4'd0 && n < 20) begin @(negedge c_clk); n++; end
    vectors++;
    if (req_cmd_out !== 4'd5) begin
      miscompares++; $display("FAIL tmo_op1: got %h want 5", req_cmd_out);
    end
`ifdef CALC_REQ_TIMEOUT_EN
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin @(negedge c_clk); n++; end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vectors++;
    if (rsp_valid !== 1'b1 || {rsp_cmd, rsp_resp, rsp_data} !== e) begin
      miscompares++;
      $display("FAIL tmo_rsp: got v=%b %h/%h/%h want 1 %h/%h/%h",
               rsp_valid, rsp_cmd, rsp_resp, rsp_data, e.cmd, e.resp, e.data);
    end
    vectors++;
    if (n != 65) begin
      miscompares++; $display("FAIL tmo_latency: rsp after %0d cycles want 65", n);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
`else
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    repeat (1000) @(negedge c_clk);
    vectors++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_cmd_out !== 4'd0) begin
      miscompares++;
      $display("FAIL tmo_absent: busy=%b rsp_valid=%b req=%h want 1/0/0 (pending %h)",
               busy, rsp_valid, req_cmd_out, e.cmd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_noop();
    test_reset_in_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
